// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory path: op codes, memory bounds
// and the load/store initiator state encoding.
package mips_mem_pkg;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    // Implemented word window, shared with the data memory model.
    localparam int DEF_MEM_LO_WORD = 250;
    localparam int DEF_MEM_HI_WORD = 2499;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_t;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:          bad = (off != 2'd0);
            OP_LH, OP_LHU, OP_SH:  bad = off[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Sub-word stores must read the old word first.
    function automatic logic is_rmw(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte/halfword lane steering: load extract with sign/zero
// extension, and sub-word merge for read-modify-write stores.
import mips_mem_pkg::*;

module dmem_lane_align #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    input  logic [15:0] store_data,
    output logic [31:0] load_result,
    output logic [31:0] merged_word
);

    logic [1:0]  byte_lane;
    logic        half_hi;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane 0 is bits[7:0]; big-endian byte offset 0 lives in lane 3.
    always_comb begin
        byte_lane = BIG_ENDIAN ? (2'd3 - offset) : offset;
        half_hi   = BIG_ENDIAN ? ~offset[1] : offset[1];
        case (byte_lane)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = half_hi ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_result = 32'd0;
        case (op)
            OP_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_result = {24'd0, sel_byte};
            OP_LH:   load_result = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_result = {16'd0, sel_half};
            OP_LW:   load_result = word;
            default: load_result = 32'd0;
        endcase
    end

    always_comb begin
        merged_word = word;
        if (op == OP_SB) begin
            case (byte_lane)
                2'd0:    merged_word[7:0]   = store_data[7:0];
                2'd1:    merged_word[15:8]  = store_data[7:0];
                2'd2:    merged_word[23:16] = store_data[7:0];
                default: merged_word[31:24] = store_data[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (half_hi) begin
                merged_word[31:16] = store_data;
            end else begin
                merged_word[15:0] = store_data;
            end
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store initiator between the execute/mem stage and the word-addressed
// data memory; sub-word stores are done as read-modify-write.
import mips_mem_pkg::*;

module dmem_access_unit #(
    parameter int MEM_LO_WORD = DEF_MEM_LO_WORD,
    parameter int MEM_HI_WORD = DEF_MEM_HI_WORD,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write
);

    dmem_state_t state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [31:0] word_idx;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_result;
    logic [31:0] merged_word;

    always_comb begin
        word_idx     = {2'b00, req_addr[31:2]};
        out_of_range = (word_idx < 32'(MEM_LO_WORD)) || (word_idx > 32'(MEM_HI_WORD));
        req_err      = out_of_range || is_misaligned(req_op, req_addr[1:0]);
    end

    dmem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .word        (mem_rdata),
        .offset      (off_q),
        .op          (op_q),
        .store_data  (wdata_q),
        .load_result (load_result),
        .merged_word (merged_word)
    );

    // Every output is a flop so the memory only ever sees clean strobe edges;
    // DONE and IDLE guarantee at least one low-strobe cycle between accesses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            op_q       <= OP_LB;
            off_q      <= 2'd0;
            wdata_q    <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= word_idx;
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_op == OP_SW) begin
                            state     <= ST_WR;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= ST_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    mem_read <= 1'b0;
                    if (is_rmw(op_q)) begin
                        state     <= ST_WR;
                        mem_write <= 1'b1;
                        mem_wdata <= merged_word;
                    end else begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_result;
                    end
                end
                ST_WR: begin
                    mem_write  <= 1'b0;
                    state      <= ST_DONE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit against a byte-addressed
// big-endian reference memory and a word-wide memory model.
import mips_mem_pkg::*;

module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;

    int errors = 0;
    int checks = 0;

    dmem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write)
    );

    always #5 clk = ~clk;

    // Word memory model: unwritten words read back a fixed pattern.
    bit [31:0] mem     [0:4095];
    bit        written [0:4095];

    function automatic logic [31:0] seed_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_rdata = written[mem_addr[11:0]] ? mem[mem_addr[11:0]]
                                               : seed_word(int'(mem_addr[11:0]));

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[11:0]]     <= mem_wdata;
            written[mem_addr[11:0]] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_read === 1'b1 && mem_write === 1'b1) begin
            errors++;
            $display("[TB] FAIL strobe_overlap: mem_read=1 mem_write=1 at %0t, required never both", $time);
        end
    end

    // Reference: byte-addressed big-endian memory.
    logic [7:0] ref_bytes [0:16383];

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w], ref_bytes[4*w+1], ref_bytes[4*w+2], ref_bytes[4*w+3]};
    endfunction

    task automatic ref_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr, output logic [31:0] wword);
        int a;
        int w;
        logic [7:0]  b;
        logic [15:0] h;
        a = int'(addr);
        w = int'(addr >> 2);
        rdata = 32'd0; err = 1'b0; lat = 2; nrd = 0; nwr = 0; wword = 32'd0;
        if (((op == OP_LW || op == OP_SW) && (addr % 4 != 0)) ||
            ((op == OP_LH || op == OP_LHU || op == OP_SH) && (addr % 2 != 0)) ||
            (addr >> 2) < 250 || (addr >> 2) > 2499) begin
            err = 1'b1; lat = 1;
        end else begin
            b = ref_bytes[a];
            h = {ref_bytes[a], ref_bytes[a+1]};
            case (op)
                OP_LB:  begin nrd = 1; rdata = (b >= 8'd128) ? (32'hFFFFFF00 | 32'(b)) : 32'(b); end
                OP_LBU: begin nrd = 1; rdata = 32'(b); end
                OP_LH:  begin nrd = 1; rdata = (h >= 16'h8000) ? (32'hFFFF0000 | 32'(h)) : 32'(h); end
                OP_LHU: begin nrd = 1; rdata = 32'(h); end
                OP_LW:  begin nrd = 1; rdata = ref_word(w); end
                OP_SB:  begin nrd = 1; nwr = 1; lat = 3; ref_bytes[a] = wdata[7:0]; end
                OP_SH:  begin
                    nrd = 1; nwr = 1; lat = 3;
                    ref_bytes[a] = wdata[15:8]; ref_bytes[a+1] = wdata[7:0];
                end
                default: begin
                    nwr = 1;
                    ref_bytes[a] = wdata[31:24]; ref_bytes[a+1] = wdata[23:16];
                    ref_bytes[a+2] = wdata[15:8]; ref_bytes[a+3] = wdata[7:0];
                end
            endcase
            wword = ref_word(w);
        end
    endtask

    // Issues one request and observes it to its response.
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nrd, output int nwr, output logic [31:0] waddr,
                         output logic [31:0] wword, output bit timeout);
        int waitc;
        rdata = 32'hX; err = 1'bX; lat = 0; nrd = 0; nwr = 0;
        waddr = 32'd0; wword = 32'd0; timeout = 1'b0;
        waitc = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (req_ready !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int i = 0; i < 8; i++) begin
            lat++;
            if (mem_read === 1'b1) nrd++;
            if (mem_write === 1'b1) begin
                nwr++; waddr = mem_addr; wword = mem_wdata;
            end
            if (resp_valid === 1'b1) begin
                rdata = resp_rdata; err = resp_err;
                return;
            end
            @(negedge clk);
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_op = OP_LB; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (req_ready  !== 1'b1)  begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
        if (resp_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
        if (resp_err   !== 1'b0)  begin errors++; $display("[TB] FAIL reset_resp_err: got %b want 0", resp_err); end
        if (resp_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", resp_rdata); end
        if (mem_read   !== 1'b0)  begin errors++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
        if (mem_write  !== 1'b0)  begin errors++; $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write); end
        if (mem_addr   !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        if (mem_wdata  !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops    [7] = '{OP_SW, OP_LB, OP_LBU, OP_SB, OP_LW, OP_LH, OP_LW};
        logic [31:0] addrs  [7] = '{32'h3E8, 32'h3E9, 32'h3E9, 32'h3EB, 32'h3E8, 32'h3E9, 32'h3E4};
        logic [31:0] wdatas [7] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h11, 32'h0, 32'h0, 32'h0};
        logic [31:0] xrd    [7] = '{32'h0, 32'hFFFFFFAD, 32'h000000AD, 32'h0, 32'hDEADBE11, 32'h0, 32'h0};
        logic        xerr   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int          xlat   [7] = '{2, 2, 2, 3, 2, 1, 1};
        int          xrdc   [7] = '{0, 1, 1, 1, 1, 0, 0};
        int          xwrc   [7] = '{1, 0, 0, 1, 0, 0, 0};
        logic [31:0] xww    [7] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBE11, 32'h0, 32'h0, 32'h0};
        logic [31:0] rd, ww, wa, mrd, mww;
        logic e, me;
        int lat, nrd, nwr, mlat, mnrd, mnwr;
        bit to;
        for (int i = 0; i < 7; i++) begin
            ref_op(ops[i], addrs[i], wdatas[i], mrd, me, mlat, mnrd, mnwr, mww);
            do_op(ops[i], addrs[i], wdatas[i], rd, e, lat, nrd, nwr, wa, ww, to);
            checks += 5;
            if (to) begin
                errors++; $display("[TB] FAIL dir%0d_timeout: no response within bound", i);
                continue;
            end
            if (rd !== xrd[i])   begin errors++; $display("[TB] FAIL dir%0d_rdata: got %h want %h", i, rd, xrd[i]); end
            if (e !== xerr[i])   begin errors++; $display("[TB] FAIL dir%0d_err: got %b want %b", i, e, xerr[i]); end
            if (lat != xlat[i])  begin errors++; $display("[TB] FAIL dir%0d_latency: got %0d want %0d", i, lat, xlat[i]); end
            if (nrd != xrdc[i] || nwr != xwrc[i]) begin
                errors++; $display("[TB] FAIL dir%0d_strobes: got rd=%0d wr=%0d want rd=%0d wr=%0d", i, nrd, nwr, xrdc[i], xwrc[i]);
            end
            if (xwrc[i] == 1 && (ww !== xww[i] || wa !== 32'd250)) begin
                errors++; $display("[TB] FAIL dir%0d_write: got addr=%0d data=%h want addr=250 data=%h", i, wa, ww, xww[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ww, wa, mrd, mww, addr, wd;
        logic [2:0] op;
        logic e, me;
        int lat, nrd, nwr, mlat, mnrd, mnwr, widx, sel;
        bit to;
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: widx = 249;
                1: widx = 250;
                2: widx = 2499;
                3: widx = 2500;
                default: widx = 250 + int'($urandom_range(0, 7));
            endcase
            addr = 32'(widx * 4) + 32'($urandom_range(0, 3));
            op   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            ref_op(op, addr, wd, mrd, me, mlat, mnrd, mnwr, mww);
            do_op(op, addr, wd, rd, e, lat, nrd, nwr, wa, ww, to);
            checks += 4;
            if (to) begin
                errors++; $display("[TB] FAIL rnd%0d_timeout: op=%0d addr=%h no response", i, op, addr);
                continue;
            end
            if (rd !== mrd || e !== me) begin
                errors++; $display("[TB] FAIL rnd%0d_resp: op=%0d addr=%h got rdata=%h err=%b want rdata=%h err=%b", i, op, addr, rd, e, mrd, me);
            end
            if (lat != mlat) begin errors++; $display("[TB] FAIL rnd%0d_latency: op=%0d got %0d want %0d", i, op, lat, mlat); end
            if (nrd != mnrd || nwr != mnwr) begin
                errors++; $display("[TB] FAIL rnd%0d_strobes: op=%0d got rd=%0d wr=%0d want rd=%0d wr=%0d", i, op, nrd, nwr, mnrd, mnwr);
            end
            if (mnwr == 1 && (ww !== mww || wa !== 32'(widx))) begin
                errors++; $display("[TB] FAIL rnd%0d_write: op=%0d got addr=%0d data=%h want addr=%0d data=%h", i, op, wa, ww, widx, mww);
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int waitc = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waitc < 20) begin @(negedge clk); waitc++; end
        req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h3EA; req_wdata = 32'hCAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_rd: mem_read got %b want 1", mem_read); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b want 1", req_ready); end
        checks++;
        for (int i = 0; i < 6; i++) begin
            if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL rst_mid_quiet: cycle %0d mem_write=%b resp_valid=%b want 0 0", i, mem_write, resp_valid);
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (mem_rdata_word(250) !== ref_word(250)) begin
            errors++; $display("[TB] FAIL rst_mid_mem: word250 got %h want %h", mem_rdata_word(250), ref_word(250));
        end
    endtask

    function automatic logic [31:0] mem_rdata_word(input int w);
        return written[w] ? mem[w] : seed_word(w);
    endfunction

    task automatic test_back_to_back();
        logic [31:0] wd [4];
        int acc = 0;
        int last = 0;
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'(260 * 4); req_wdata = wd[0];
        for (int c = 0; c < 40 && acc < 4; c++) begin
            @(negedge clk);
            if (mem_write === 1'b1 || resp_valid === 1'b1) begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_busy: got %b want 0 at cycle %0d", req_ready, c); end
            end
            if (req_ready === 1'b1) begin
                if (acc > 0) begin
                    checks++;
                    if (c - last != 3) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d edges want 3", c - last); end
                end
                last = c;
                acc++;
                @(posedge clk);
                #1;
                if (acc < 4) begin
                    req_addr = 32'((260 + acc) * 4); req_wdata = wd[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc != 4) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d want 4", acc); end
        for (int i = 0; i < 4; i++) begin
            ref_bytes[4*(260+i)]   = wd[i][31:24]; ref_bytes[4*(260+i)+1] = wd[i][23:16];
            ref_bytes[4*(260+i)+2] = wd[i][15:8];  ref_bytes[4*(260+i)+3] = wd[i][7:0];
            checks++;
            if (mem_rdata_word(260 + i) !== ref_word(260 + i)) begin
                errors++; $display("[TB] FAIL b2b_mem%0d: got %h want %h", i, mem_rdata_word(260 + i), ref_word(260 + i));
            end
        end
    endtask

    initial begin
        logic [31:0] sw;
        for (int w = 0; w < 4096; w++) begin
            sw = seed_word(w);
            ref_bytes[4*w]   = sw[31:24]; ref_bytes[4*w+1] = sw[23:16];
            ref_bytes[4*w+2] = sw[15:8];  ref_bytes[4*w+3] = sw[7:0];
        end
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

endmodule
